// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and d-legality helper for the ML-KEM
// unpack/decompress receive path.
package kyber_pkg;

  localparam int Q      = 3329;
  localparam int QW     = 12;
  localparam int N_COEF = 256;
  localparam int BUF_W  = 24;
  localparam int XW     = 11;
  localparam int PW     = 24;
  localparam int CNT_W  = 5;
  localparam int BL_W   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic d_legal(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: d_legal = 1'b1;
      default:                        d_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kyber_unpack_decompress_if.sv
// Control, byte-stream and coefficient-stream bundle of the unpack/decompress
// block; slave is the block side, master is the driver side.
interface kyber_unpack_decompress_if;
  import kyber_pkg::*;

  logic          start;
  logic [3:0]    d_sel;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [QW-1:0] coeff_out;
  logic [7:0]    coeff_idx;
  logic          coeff_valid;
  logic          coeff_ready;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  start, d_sel, byte_in, byte_valid, coeff_ready,
    output byte_ready, coeff_out, coeff_idx, coeff_valid, busy, done, err
  );

  modport master (
    output start, d_sel, byte_in, byte_valid, coeff_ready,
    input  byte_ready, coeff_out, coeff_idx, coeff_valid, busy, done, err
  );

endinterface

// File: rtl/kyber_decompress_core.sv
// Two-stage decompress pipeline: stage 1 forms x*Q + 2^(d-1), stage 2 drops
// the low d bits, giving round(x*Q/2^d) which is always below Q.
module kyber_decompress_core
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] x,
  input  logic [3:0]    d,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic [QW-1:0] coeff,
  output logic          out_valid,
  output logic          in_ready
);

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] p_q, p_d;
  logic [QW-1:0] coeff_q, coeff_d;
  logic          out_valid_q, out_valid_d;
  logic          s2_adv_s;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    coeff_d     = coeff_q;
    s2_adv_s    = out_ready || !out_valid_q;
    in_ready    = !s1_valid_q || s2_adv_s;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        p_d = PW'(x) * PW'(Q) + (PW'(1) << (d - 4'd1));
      end else begin
        p_d = p_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        coeff_d = QW'(p_q >> d);
      end else begin
        coeff_d = coeff_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      coeff_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      coeff_q     <= coeff_d;
    end
  end

  assign coeff     = coeff_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/kyber_unpack_decompress.sv
// Unpacks a little-endian bit-packed byte stream into d-bit fields and feeds
// them to the decompress pipeline, one polynomial (256 coefficients) per start.
module kyber_unpack_decompress
  import kyber_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  kyber_unpack_decompress_if.slave   bus
);

  state_e             state_q, state_d;
  logic [3:0]         d_q, d_d;
  logic [BL_W-1:0]    bytes_left_q, bytes_left_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         coef_cnt_q, coef_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               byte_ready_s, in_valid_s, extract_s, accept_s, coef_hs_s;
  logic [XW-1:0]      x_s;
  logic [BUF_W-1:0]   shifted_s;
  logic [CNT_W-1:0]   pos_s;
  logic               core_in_ready_s, core_valid_s;
  logic [QW-1:0]      core_coeff_s;

  kyber_decompress_core u_core (
    .clk       (clk),
    .rst       (rst),
    .x         (x_s),
    .d         (d_q),
    .in_valid  (in_valid_s),
    .out_ready (bus.coeff_ready),
    .coeff     (core_coeff_s),
    .out_valid (core_valid_s),
    .in_ready  (core_in_ready_s)
  );

  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    bytes_left_d = bytes_left_q;
    buf_d        = buf_q;
    bit_cnt_d    = bit_cnt_q;
    coef_cnt_d   = coef_cnt_q;
    err_d        = 1'b0;

    byte_ready_s = (state_q == RUN) && (bytes_left_q != '0) &&
                   (bit_cnt_q <= CNT_W'(BUF_W - 8));
    in_valid_s   = (state_q == RUN) && (bit_cnt_q >= {1'b0, d_q});
    x_s          = buf_q[XW-1:0] & ((XW'(1) << d_q) - XW'(1));
    extract_s    = in_valid_s && core_in_ready_s;
    accept_s     = bus.byte_valid && byte_ready_s;
    coef_hs_s    = core_valid_s && bus.coeff_ready;

    // An incoming byte lands just above the bits left after this cycle's extract.
    shifted_s = extract_s ? (buf_q >> d_q) : buf_q;
    pos_s     = extract_s ? (bit_cnt_q - {1'b0, d_q}) : bit_cnt_q;
    if (accept_s) begin
      buf_d        = shifted_s | (BUF_W'(bus.byte_in) << pos_s);
      bit_cnt_d    = pos_s + CNT_W'(8);
      bytes_left_d = bytes_left_q - BL_W'(1);
    end else begin
      buf_d     = shifted_s;
      bit_cnt_d = pos_s;
    end

    if (coef_hs_s) begin
      coef_cnt_d = coef_cnt_q + 8'd1;
    end else begin
      coef_cnt_d = coef_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (d_legal(bus.d_sel)) begin
            state_d      = RUN;
            d_d          = bus.d_sel;
            bytes_left_d = {bus.d_sel, 5'd0};
            coef_cnt_d   = 8'd0;
            buf_d        = '0;
            bit_cnt_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (coef_hs_s && (coef_cnt_q == 8'd255)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      d_q          <= 4'd0;
      bytes_left_q <= '0;
      buf_q        <= '0;
      bit_cnt_q    <= '0;
      coef_cnt_q   <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      bytes_left_q <= bytes_left_d;
      buf_q        <= buf_d;
      bit_cnt_q    <= bit_cnt_d;
      coef_cnt_q   <= coef_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready  = byte_ready_s;
  assign bus.coeff_out   = core_coeff_s;
  assign bus.coeff_idx   = coef_cnt_q;
  assign bus.coeff_valid = core_valid_s;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_kyber_unpack_decompress.sv
// Directed bench with a scoreboard: expected coefficients are computed from
// the generated byte stream and compared against each output handshake.
module tb_kyber_unpack_decompress;
  import kyber_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kyber_unpack_decompress_if bus ();

  kyber_unpack_decompress dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  stim [0:351];
  int          exp_q [$];
  int          got   [0:255];
  int          ref_c [0:255];
  int          hs_cnt   = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_coeff;
  logic [7:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on every handshake, hold check while stalled.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, bus.coeff_valid}, 32'd1);
        check("hold_coeff", {20'd0, bus.coeff_out}, {20'd0, prev_coeff});
        check("hold_idx", {24'd0, bus.coeff_idx}, {24'd0, prev_idx});
      end
      if (bus.coeff_valid && bus.coeff_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_coeff observed=%0d expected=none", bus.coeff_out);
        end else begin
          e = exp_q.pop_front();
          check("coeff_val", {20'd0, bus.coeff_out}, e & 32'hFFF);
          check("coeff_idx", {24'd0, bus.coeff_idx}, e >> 16);
        end
        got[bus.coeff_idx] = int'(bus.coeff_out);
        hs_cnt++;
      end
      prev_stall = bus.coeff_valid && !bus.coeff_ready;
      prev_coeff = bus.coeff_out;
      prev_idx   = bus.coeff_idx;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_coeff_valid"}, {31'd0, bus.coeff_valid}, 32'd0);
    check({tag, "_coeff_out"}, {20'd0, bus.coeff_out}, 32'd0);
    check({tag, "_coeff_idx"}, {24'd0, bus.coeff_idx}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask

  task automatic run_poly(input int d, input bit stall, input bit gaps,
                          input bit restart, input int abort_at);
    int nb, k, cyc, x, bp, extra;
    nb = 32 * d;
    k = 0;
    cyc = 0;
    extra = 0;
    for (int i = 0; i < 256; i++) begin
      x = 0;
      for (int b = 0; b < d; b++) begin
        bp = i * d + b;
        x = x | (int'(stim[bp / 8][bp % 8]) << b);
      end
      exp_q.push_back((i << 16) | ((2 * x * Q + (1 << d)) / (1 << (d + 1))));
    end
    hs_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.d_sel = d[3:0];
    bus.byte_valid = 1'b0;
    bus.coeff_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      if (abort_at > 0 && hs_cnt >= abort_at) break;
      bus.start = restart && (cyc == 40);
      bus.d_sel = restart ? 4'd1 : d[3:0];
      bus.byte_valid = (k < nb) && (!gaps || ($urandom_range(0, 3) != 0));
      bus.byte_in = (k < nb) ? stim[k] : 8'h00;
      bus.coeff_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready) k++;
      cyc++;
    end
    if (abort_at > 0) begin
      bus.coeff_ready = 1'b0;
      bus.byte_valid = 1'b0;
      bus.start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("abort_no_done", done_cnt, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      exp_q.delete();
    end else begin
      bus.start = 1'b0;
      bus.coeff_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h5A;
        @(negedge clk);
        if (bus.byte_ready) extra++;
      end
      bus.byte_valid = 1'b0;
      check("done_once", done_cnt, 32'd1);
      check("coeff_count", hs_cnt, 32'd256);
      check("queue_empty", exp_q.size(), 32'd0);
      check("bytes_consumed", k, nb);
      check("no_extra_bytes", extra, 32'd0);
      check("busy_end", {31'd0, bus.busy}, 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int diff;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.d_sel = 4'd0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    bus.coeff_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Illegal width: err pulse only, no run.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.d_sel = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("illegal_err", {31'd0, bus.err}, 32'd1);
    check("illegal_busy", {31'd0, bus.busy}, 32'd0);
    check("illegal_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_err_pulse", {31'd0, bus.err}, 32'd0);
    check("illegal_busy_later", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 352; i++) stim[i] = 8'($urandom_range(0, 255));
    stim[0] = 8'hA5;
    run_poly(1, 1'b0, 1'b0, 1'b0, 0);
    check("d1_c0", got[0], 32'd1665);
    check("d1_c1", got[1], 32'd0);
    check("d1_c2", got[2], 32'd1665);
    check("d1_c3", got[3], 32'd0);
    check("d1_c4", got[4], 32'd0);
    check("d1_c5", got[5], 32'd1665);
    check("d1_c6", got[6], 32'd0);
    check("d1_c7", got[7], 32'd1665);

    for (int i = 0; i < 352; i++) stim[i] = 8'($urandom_range(0, 255));
    stim[0] = 8'h21;
    run_poly(4, 1'b0, 1'b0, 1'b0, 0);
    check("d4_c0", got[0], 32'd208);
    check("d4_c1", got[1], 32'd416);

    for (int i = 0; i < 352; i++) stim[i] = 8'hFF;
    run_poly(10, 1'b0, 1'b0, 1'b0, 0);
    check("d10_first", got[0], 32'd3326);
    check("d10_last", got[255], 32'd3326);
    run_poly(11, 1'b0, 1'b0, 1'b0, 0);
    check("d11_first", got[0], 32'd3327);
    check("d11_last", got[255], 32'd3327);

    for (int i = 0; i < 352; i++) stim[i] = 8'($urandom_range(0, 255));
    run_poly(5, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++) ref_c[i] = got[i];
    for (int i = 0; i < 256; i++) got[i] = -1;
    run_poly(5, 1'b1, 1'b1, 1'b1, 0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (got[i] != ref_c[i]) diff++;
    check("stall_vs_nostall_diffs", diff, 32'd0);

    for (int i = 0; i < 352; i++) stim[i] = 8'($urandom_range(0, 255));
    run_poly(4, 1'b0, 1'b0, 1'b0, 100);
    stim[0] = 8'h21;
    run_poly(4, 1'b0, 1'b0, 1'b0, 0);
    check("fresh_d4_c0", got[0], 32'd208);
    check("fresh_d4_c1", got[1], 32'd416);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
